mem_burst_responder: RTL and testbench

Memory-side responder for the cache memory/IO interface. It accepts read and write requests from a D-cache or I-cache, serves them from an internal word array, and returns read bursts or sinks write bursts. It sits between the cache and the rest of the memory system and is the bench and FPGA memory model for cache bring-up. Requests are served one at a time. Write requests win over simultaneous read requests, so a write-back ahead of a refill is committed first.

---
 rtl/mem_burst_responder_if.sv | 64 ++++++
 rtl/mem_burst_responder.sv | 136 +++++++++++++
 tb/tb_mem_burst_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_responder_if.sv
// Cache memory/IO bus between a D/I-cache (master) and a memory responder (slave).
// Carries the read request, read response, write request and write data channels.
interface mem_burst_responder_if;
    logic        from_cache_rd_req_valid;
    logic [31:0] from_cache_rd_req_addr;
    logic [7:0]  from_cache_rd_req_len;
    logic        to_cache_rd_req_ready;

    logic        to_cache_rd_rsp_valid;
    logic [31:0] to_cache_rd_rsp_data;
    logic        to_cache_rd_rsp_last;
    logic        from_cache_rd_rsp_ready;

    logic        from_cache_wr_req_valid;
    logic [31:0] from_cache_wr_req_addr;
    logic [7:0]  from_cache_wr_req_len;
    logic        to_cache_wr_req_ready;

    logic        from_cache_wr_data_valid;
    logic [31:0] from_cache_wr_data;
    logic [3:0]  from_cache_wr_data_strb;
    logic        from_cache_wr_data_last;
    logic        to_cache_wr_data_ready;

    modport master (
        output from_cache_rd_req_valid,
        output from_cache_rd_req_addr,
        output from_cache_rd_req_len,
        input  to_cache_rd_req_ready,
        input  to_cache_rd_rsp_valid,
        input  to_cache_rd_rsp_data,
        input  to_cache_rd_rsp_last,
        output from_cache_rd_rsp_ready,
        output from_cache_wr_req_valid,
        output from_cache_wr_req_addr,
        output from_cache_wr_req_len,
        input  to_cache_wr_req_ready,
        output from_cache_wr_data_valid,
        output from_cache_wr_data,
        output from_cache_wr_data_strb,
        output from_cache_wr_data_last,
        input  to_cache_wr_data_ready
    );

    modport slave (
        input  from_cache_rd_req_valid,
        input  from_cache_rd_req_addr,
        input  from_cache_rd_req_len,
        output to_cache_rd_req_ready,
        output to_cache_rd_rsp_valid,
        output to_cache_rd_rsp_data,
        output to_cache_rd_rsp_last,
        input  from_cache_rd_rsp_ready,
        input  from_cache_wr_req_valid,
        input  from_cache_wr_req_addr,
        input  from_cache_wr_req_len,
        output to_cache_wr_req_ready,
        input  from_cache_wr_data_valid,
        input  from_cache_wr_data,
        input  from_cache_wr_data_strb,
        input  from_cache_wr_data_last,
        output to_cache_wr_data_ready
    );
endinterface

// File: rtl/mem_burst_responder.sv
// Memory-side burst responder: serves cache read/write bursts from a word array.
// Ports: clk, rst (async active-low), bus (slave side of the cache bus), err (sticky).
module mem_burst_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_burst_responder_if.slave bus,
    output logic                 err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RD_BEAT = 2'd2;
    localparam logic [1:0] S_WR_BEAT = 2'd3;

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [3:0]  LAT_INI = 4'(RD_LAT - 1);

    logic [1:0]        state;
    logic              alive;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        cnt;
    logic [7:0]        len;
    logic [3:0]        lat;

    // Not reset: contents survive a reset of the control path.
    logic [31:0] mem [DEPTH];

    logic idle;
    logic wr_hs;
    logic rd_hs;
    logic beat_last;
    logic rd_take;
    logic wr_take;
    logic wr_last_bad;

    assign idle      = (state == S_IDLE);
    assign beat_last = (cnt == len);

    // Writes win arbitration: read ready is masked while a write request is up.
    assign bus.to_cache_wr_req_ready = alive && idle;
    assign bus.to_cache_rd_req_ready = alive && idle &&
                                       !bus.from_cache_wr_req_valid;

    assign wr_hs = bus.from_cache_wr_req_valid && bus.to_cache_wr_req_ready;
    assign rd_hs = bus.from_cache_rd_req_valid && bus.to_cache_rd_req_ready;

    assign bus.to_cache_rd_rsp_valid  = (state == S_RD_BEAT);
    assign bus.to_cache_rd_rsp_data   = bus.to_cache_rd_rsp_valid ? mem[ptr] : 32'h0;
    assign bus.to_cache_rd_rsp_last   = bus.to_cache_rd_rsp_valid && beat_last;
    assign bus.to_cache_wr_data_ready = (state == S_WR_BEAT);

    assign rd_take = bus.to_cache_rd_rsp_valid && bus.from_cache_rd_rsp_ready;
    assign wr_take = bus.to_cache_wr_data_ready && bus.from_cache_wr_data_valid;

    // The beat count ends the burst; a disagreeing last flag is only flagged.
    assign wr_last_bad = wr_take && (bus.from_cache_wr_data_last != beat_last);

    // Byte-address low bits and bits above the array aliasing range are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.from_cache_rd_req_addr[31:ADDR_W+2],
                                bus.from_cache_rd_req_addr[1:0],
                                bus.from_cache_wr_req_addr[31:ADDR_W+2],
                                bus.from_cache_wr_req_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive <= 1'b0;
            state <= S_IDLE;
            ptr   <= '0;
            cnt   <= 8'd0;
            len   <= 8'd0;
            lat   <= 4'd0;
            err   <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (wr_last_bad)
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (wr_hs) begin
                        ptr   <= bus.from_cache_wr_req_addr[ADDR_W+1:2];
                        len   <= bus.from_cache_wr_req_len;
                        cnt   <= 8'd0;
                        state <= S_WR_BEAT;
                    end else if (rd_hs) begin
                        ptr   <= bus.from_cache_rd_req_addr[ADDR_W+1:2];
                        len   <= bus.from_cache_rd_req_len;
                        cnt   <= 8'd0;
                        lat   <= LAT_INI;
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lat == 4'd0)
                        state <= S_RD_BEAT;
                    else
                        lat <= lat - 4'd1;
                end
                S_RD_BEAT: begin
                    if (rd_take) begin
                        if (beat_last) begin
                            state <= S_IDLE;
                        end else begin
                            ptr <= ptr + 1'b1;
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_WR_BEAT: begin
                    if (wr_take) begin
                        if (beat_last) begin
                            state <= S_IDLE;
                        end else begin
                            ptr <= ptr + 1'b1;
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_take) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.from_cache_wr_data_strb[b])
                    mem[ptr][8*b +: 8] <= bus.from_cache_wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder with hand-computed expectations.
// Covers reset, line write/refill, strobes, backpressure, arbitration, wrap, err.
module tb_mem_burst_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic exp_err = 1'b0;

    logic [31:0] got_d [16];
    logic        got_l [16];
    int          n_beats;
    int          first_lat;

    mem_burst_responder_if bus();

    mem_burst_responder #(
        .ADDR_W(10),
        .RD_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_flags"},
              {26'd0, bus.to_cache_wr_req_ready, bus.to_cache_rd_req_ready,
               bus.to_cache_rd_rsp_valid, bus.to_cache_rd_rsp_last,
               bus.to_cache_wr_data_ready, err}, 32'd0);
        check({tag, "_data"}, bus.to_cache_rd_rsp_data, 32'd0);
    endtask

    // Drives len+1 write beats starting at a negedge; beat "bad" carries last=1.
    task automatic wr_beats(input int len, input logic [31:0] d0,
                            input logic [3:0] strb, input int bad);
        int k;
        for (int i = 0; i <= len; i++) begin
            bus.from_cache_wr_data_valid = 1'b1;
            bus.from_cache_wr_data       = d0 + 32'(i);
            bus.from_cache_wr_data_strb  = strb;
            bus.from_cache_wr_data_last  = (i == len) || (i == bad);
            if (bus.from_cache_wr_data_last != (i == len))
                exp_err = 1'b1;
            #1;
            k = 0;
            while (!bus.to_cache_wr_data_ready && k < 50) begin
                @(negedge clk);
                #1;
                k++;
            end
            if (!bus.to_cache_wr_data_ready) begin
                check("wr_beat_timeout", {31'd0, bus.to_cache_wr_data_ready}, 32'd1);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
            check("wr_err", {31'd0, err}, {31'd0, exp_err});
        end
        bus.from_cache_wr_data_valid = 1'b0;
        bus.from_cache_wr_data_last  = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len,
                               input logic [31:0] d0, input logic [3:0] strb,
                               input int bad);
        int k;
        @(negedge clk);
        bus.from_cache_wr_req_valid = 1'b1;
        bus.from_cache_wr_req_addr  = addr;
        bus.from_cache_wr_req_len   = 8'(len);
        #1;
        k = 0;
        while (!bus.to_cache_wr_req_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!bus.to_cache_wr_req_ready) begin
            check("wr_req_timeout", {31'd0, bus.to_cache_wr_req_ready}, 32'd1);
            bus.from_cache_wr_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.from_cache_wr_req_valid = 1'b0;
        wr_beats(len, d0, strb, bad);
    endtask

    // Collects one read burst; bp selects the 1,0,0 rsp_ready pattern.
    task automatic read_burst(input logic [31:0] addr, input int len, input bit bp);
        int k;
        int j;
        int hs;
        bit done;
        bit have_prev;
        logic [31:0] prev_d;
        logic prev_l;
        @(negedge clk);
        bus.from_cache_rd_req_valid = 1'b1;
        bus.from_cache_rd_req_addr  = addr;
        bus.from_cache_rd_req_len   = 8'(len);
        bus.from_cache_rd_rsp_ready = 1'b0;
        #1;
        k = 0;
        while (!bus.to_cache_rd_req_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_beats   = 0;
        first_lat = -1;
        if (!bus.to_cache_rd_req_ready) begin
            check("rd_req_timeout", {31'd0, bus.to_cache_rd_req_ready}, 32'd1);
            bus.from_cache_rd_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.from_cache_rd_req_valid = 1'b0;
        hs        = cyc;
        done      = 1'b0;
        have_prev = 1'b0;
        prev_d    = 32'd0;
        prev_l    = 1'b0;
        j         = 0;
        while (!done && j < 100) begin
            bus.from_cache_rd_rsp_ready = bp ? (j % 3 == 0) : 1'b1;
            #1;
            if (bus.to_cache_rd_rsp_valid) begin
                if (first_lat < 0)
                    first_lat = cyc - hs;
                if (have_prev) begin
                    check("hold_data", bus.to_cache_rd_rsp_data, prev_d);
                    check("hold_last", {31'd0, bus.to_cache_rd_rsp_last},
                          {31'd0, prev_l});
                end
                if (bus.from_cache_rd_rsp_ready) begin
                    if (n_beats < 16) begin
                        got_d[n_beats] = bus.to_cache_rd_rsp_data;
                        got_l[n_beats] = bus.to_cache_rd_rsp_last;
                    end
                    n_beats++;
                    have_prev = 1'b0;
                    if (bus.to_cache_rd_rsp_last)
                        done = 1'b1;
                end else begin
                    have_prev = 1'b1;
                    prev_d    = bus.to_cache_rd_rsp_data;
                    prev_l    = bus.to_cache_rd_rsp_last;
                end
            end
            @(negedge clk);
            j++;
        end
        bus.from_cache_rd_rsp_ready = 1'b0;
        check("rd_burst_done", {31'd0, done}, 32'd1);
    endtask

    // Expects len+1 beats counting up from d0, last only on the final one.
    task automatic verify_burst(input string tag, input int len,
                                input logic [31:0] d0);
        check({tag, "_beats"}, 32'(n_beats), 32'(len + 1));
        check({tag, "_lat"}, 32'(first_lat), 32'd2);
        for (int i = 0; i <= len && i < n_beats && i < 16; i++) begin
            check($sformatf("%s_d%0d", tag, i), got_d[i], d0 + 32'(i));
            check($sformatf("%s_l%0d", tag, i), {31'd0, got_l[i]},
                  {31'd0, (i == len)});
        end
    endtask

    initial begin
        bus.from_cache_rd_req_valid  = 1'b0;
        bus.from_cache_rd_req_addr   = 32'd0;
        bus.from_cache_rd_req_len    = 8'd0;
        bus.from_cache_rd_rsp_ready  = 1'b0;
        bus.from_cache_wr_req_valid  = 1'b0;
        bus.from_cache_wr_req_addr   = 32'd0;
        bus.from_cache_wr_req_len    = 8'd0;
        bus.from_cache_wr_data_valid = 1'b0;
        bus.from_cache_wr_data       = 32'd0;
        bus.from_cache_wr_data_strb  = 4'd0;
        bus.from_cache_wr_data_last  = 1'b0;

        // Reset and release
        repeat (3) @(negedge clk);
        #1;
        outs_zero("reset");
        rst = 1'b1;
        #1;
        check("rdy_first_cycle", {31'd0, bus.to_cache_rd_req_ready}, 32'd0);
        outs_zero("first_cycle");
        @(negedge clk);
        #1;
        check("rdy_after_alive", {31'd0, bus.to_cache_rd_req_ready}, 32'd1);

        // Line write then refill
        write_burst(32'h100, 7, 32'hA0, 4'hF, -1);
        read_burst(32'h100, 7, 1'b0);
        verify_burst("refill", 7, 32'hA0);

        // Partial strobe
        write_burst(32'h40, 0, 32'h11223344, 4'hF, -1);
        write_burst(32'h40, 0, 32'hAABBCCDD, 4'b0101, -1);
        read_burst(32'h40, 0, 1'b0);
        check("strb_beats", 32'(n_beats), 32'd1);
        check("strb_data", got_d[0], 32'h11BB33DD);
        check("strb_last", {31'd0, got_l[0]}, 32'd1);

        // Backpressure
        read_burst(32'h100, 7, 1'b1);
        verify_burst("bp", 7, 32'hA0);

        // Arbitration: write taken over a simultaneous read, then wrap
        @(negedge clk);
        bus.from_cache_rd_req_valid = 1'b1;
        bus.from_cache_rd_req_addr  = 32'hFF8;
        bus.from_cache_rd_req_len   = 8'd3;
        bus.from_cache_wr_req_valid = 1'b1;
        bus.from_cache_wr_req_addr  = 32'hFF8;
        bus.from_cache_wr_req_len   = 8'd3;
        #1;
        check("arb_wr_rdy", {31'd0, bus.to_cache_wr_req_ready}, 32'd1);
        check("arb_rd_rdy", {31'd0, bus.to_cache_rd_req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.from_cache_wr_req_valid = 1'b0;
        #1;
        check("arb_wr_beat_rdy", {31'd0, bus.to_cache_wr_data_ready}, 32'd1);
        check("arb_rd_wait", {31'd0, bus.to_cache_rd_req_ready}, 32'd0);
        bus.from_cache_rd_req_valid = 1'b0;
        wr_beats(3, 32'hC0, 4'hF, -1);
        read_burst(32'hFF8, 3, 1'b0);
        verify_burst("wrap", 3, 32'hC0);
        read_burst(32'h1000, 0, 1'b0);
        check("alias_w0", got_d[0], 32'hC2);
        read_burst(32'hF004, 0, 1'b0);
        check("alias_w1", got_d[0], 32'hC3);

        // Protocol error: early last on beat 2, burst still 4 beats
        check("err_clean", {31'd0, err}, {31'd0, exp_err});
        write_burst(32'h200, 3, 32'hD0, 4'hF, 2);
        #1;
        check("perr_wdr_low", {31'd0, bus.to_cache_wr_data_ready}, 32'd0);
        check("perr_idle", {31'd0, bus.to_cache_wr_req_ready}, 32'd1);
        read_burst(32'h200, 3, 1'b0);
        verify_burst("perr", 3, 32'hD0);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Async reset in the middle of a read beat
        @(negedge clk);
        bus.from_cache_rd_req_valid = 1'b1;
        bus.from_cache_rd_req_addr  = 32'h100;
        bus.from_cache_rd_req_len   = 8'd7;
        bus.from_cache_rd_rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.from_cache_rd_req_valid = 1'b0;
        #1;
        for (int k = 0; k < 20 && !bus.to_cache_rd_rsp_valid; k++) begin
            @(negedge clk);
            #1;
        end
        check("mid_beat_valid", {31'd0, bus.to_cache_rd_rsp_valid}, 32'd1);
        #1;
        rst = 1'b0;
        exp_err = 1'b0;
        #1;
        outs_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_rdy_low", {31'd0, bus.to_cache_rd_req_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("rel_rdy_high", {31'd0, bus.to_cache_rd_req_ready}, 32'd1);
        read_burst(32'h100, 0, 1'b0);
        check("persist_data", got_d[0], 32'hA0);
        check("persist_err", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
